// File: rtl/battleship_pkg.sv
// Shared types and constants for the battleship match controller.
//  cell_t         : per-cell board state, 2 bits (EMPTY, SHIP, MISS, HIT)
//  match_state_t  : turn controller states
//  LFSR_TAPS      : feedback mask for x^16+x^14+x^13+x^11 (bits 15,13,12,10)
//  cell_tried()   : 1 when a cell has already been fired on (MISS or HIT)
package battleship_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        SHIP  = 2'd1,
        MISS  = 2'd2,
        HIT   = 2'd3
    } cell_t;

    typedef enum logic [2:0] {
        IDLE,
        P_SELECT,
        RESOLVE,
        PC_PICK,
        PC_FIRE,
        GAME_OVER
    } match_state_t;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // MISS and HIT are the only encodings with the upper bit set.
    function automatic logic cell_tried(input cell_t c);
        return c[1];
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used as the PC shot source.
//  clk   in  1   clock
//  rst   in  1   asynchronous active-low reset, loads SEED
//  value out 16  current LFSR state
module lfsr16
    import battleship_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] value
);

    logic [15:0] value_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_reg <= SEED;
        end else begin
            value_reg <= {value_reg[14:0], ^(value_reg & LFSR_TAPS)};
        end
    end

    assign value = value_reg;

endmodule

// File: rtl/battleship_match_ctrl.sv
// Turn controller for one battleship match, player vs PC, on an N x N grid.
// Holds both boards and lives, alternates turns, enforces the player
// timeout, picks PC shots from an LFSR (skipping tried cells) and declares
// the winner.
//  clk, rst                 clock, asynchronous active-low reset
//  start                    1-cycle pulse, starts a match from IDLE/GAME_OVER
//  player_ships, pc_ships   N*N ship bitmaps, idx = row*N+col
//  btn_up/down/left/right   cursor move pulses
//  btn_fire                 fire at cursor
//  cursor_row/col           player cursor
//  player_turn              waiting for the player shot
//  shot_valid (+by_pc, hit, row, col)  resolved-shot pulse and its details
//  player_life, pc_life     remaining ship cells
//  timeout_evt, repeat_err  player forfeit / fired on tried cell pulses
//  game_over, player_won    match result
//  player_board, pc_board   2 bits per cell; pc_board hides SHIP cells
module battleship_match_ctrl
    import battleship_pkg::*;
#(
    parameter int          N          = 5,
    parameter int          SHIP_CELLS = 15,
    parameter int          TIMEOUT    = 750000,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    localparam int         R          = (N > 1) ? $clog2(N) : 1,
    localparam int         L          = (SHIP_CELLS > 0) ? $clog2(SHIP_CELLS + 1) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N*N-1:0]     player_ships,
    input  logic [N*N-1:0]     pc_ships,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_fire,
    output logic [R-1:0]       cursor_row,
    output logic [R-1:0]       cursor_col,
    output logic               player_turn,
    output logic               shot_valid,
    output logic               shot_by_pc,
    output logic               shot_hit,
    output logic [R-1:0]       shot_row,
    output logic [R-1:0]       shot_col,
    output logic [L-1:0]       player_life,
    output logic [L-1:0]       pc_life,
    output logic               timeout_evt,
    output logic               repeat_err,
    output logic               game_over,
    output logic               player_won,
    output logic [2*N*N-1:0]   player_board,
    output logic [2*N*N-1:0]   pc_board
);

    localparam int CELLS = N * N;
    localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    match_state_t     state_reg, state_next;
    cell_t            pl_cells_reg [CELLS];
    cell_t            pc_cells_reg [CELLS];
    logic [R-1:0]     row_reg, row_next, col_reg, col_next;
    logic [TMO_W-1:0] tmo_reg, tmo_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic             pick_first_reg, pick_first_next;
    logic [L-1:0]     pl_life_reg, pl_life_next, pc_life_reg, pc_life_next;
    logic             shot_valid_reg, shot_valid_next;
    logic             shot_by_pc_reg, shot_by_pc_next;
    logic             shot_hit_reg, shot_hit_next;
    logic [R-1:0]     shot_row_reg, shot_row_next, shot_col_reg, shot_col_next;
    logic             timeout_reg, timeout_next;
    logic             repeat_reg, repeat_next;
    logic             won_reg, won_next;

    // Board write requests produced by the FSM.
    logic             load_boards;
    logic             pc_wr_en, pl_wr_en;
    cell_t            pc_wr_val, pl_wr_val;

    logic [15:0]      lfsr_val;
    logic [IDX_W-1:0] cur_idx, lfsr_idx;
    logic [R-1:0]     pick_row, pick_col;
    cell_t            cur_cell, pick_cell;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .value (lfsr_val)
    );

    assign cur_idx   = IDX_W'(row_reg) * IDX_W'(N) + IDX_W'(col_reg);
    assign cur_cell  = pc_cells_reg[cur_idx];
    assign pick_cell = pl_cells_reg[idx_reg];
    assign lfsr_idx  = IDX_W'(lfsr_val % 16'(CELLS));
    assign pick_row  = R'(idx_reg / IDX_W'(N));
    assign pick_col  = R'(idx_reg % IDX_W'(N));

    always_comb begin
        state_next      = state_reg;
        row_next        = row_reg;
        col_next        = col_reg;
        tmo_next        = tmo_reg;
        idx_next        = idx_reg;
        pick_first_next = 1'b0;
        pl_life_next    = pl_life_reg;
        pc_life_next    = pc_life_reg;
        shot_valid_next = 1'b0;
        shot_by_pc_next = shot_by_pc_reg;
        shot_hit_next   = shot_hit_reg;
        shot_row_next   = shot_row_reg;
        shot_col_next   = shot_col_reg;
        timeout_next    = 1'b0;
        repeat_next     = 1'b0;
        won_next        = won_reg;
        load_boards     = 1'b0;
        pc_wr_en        = 1'b0;
        pc_wr_val       = EMPTY;
        pl_wr_en        = 1'b0;
        pl_wr_val       = EMPTY;

        case (state_reg)
            IDLE, GAME_OVER: begin
                if (start) begin
                    load_boards  = 1'b1;
                    pl_life_next = L'(SHIP_CELLS);
                    pc_life_next = L'(SHIP_CELLS);
                    row_next     = '0;
                    col_next     = '0;
                    tmo_next     = '0;
                    won_next     = 1'b0;
                    state_next   = P_SELECT;
                end
            end

            P_SELECT: begin
                if (btn_fire && !cell_tried(cur_cell)) begin
                    // A valid fire wins even on the last timeout cycle.
                    pc_wr_en        = 1'b1;
                    pc_wr_val       = (cur_cell == SHIP) ? HIT : MISS;
                    if (cur_cell == SHIP && pc_life_reg != '0) begin
                        pc_life_next = pc_life_reg - L'(1);
                    end
                    shot_valid_next = 1'b1;
                    shot_by_pc_next = 1'b0;
                    shot_hit_next   = (cur_cell == SHIP);
                    shot_row_next   = row_reg;
                    shot_col_next   = col_reg;
                    state_next      = RESOLVE;
                end else begin
                    // Here btn_fire can only mean a tried cell.
                    repeat_next = btn_fire;
                    if (tmo_reg == TMO_W'(TIMEOUT - 1)) begin
                        timeout_next    = 1'b1;
                        pick_first_next = 1'b1;
                        state_next      = PC_PICK;
                    end else begin
                        tmo_next = tmo_reg + TMO_W'(1);
                        if (!btn_fire) begin
                            if (btn_up) begin
                                row_next = (row_reg == '0) ? R'(N - 1) : row_reg - R'(1);
                            end else if (btn_down) begin
                                row_next = (row_reg == R'(N - 1)) ? '0 : row_reg + R'(1);
                            end
                            if (btn_left) begin
                                col_next = (col_reg == '0) ? R'(N - 1) : col_reg - R'(1);
                            end else if (btn_right) begin
                                col_next = (col_reg == R'(N - 1)) ? '0 : col_reg + R'(1);
                            end
                        end
                    end
                end
            end

            RESOLVE: begin
                if (pc_life_reg == '0) begin
                    won_next   = 1'b1;
                    state_next = GAME_OVER;
                end else if (pl_life_reg == '0) begin
                    won_next   = 1'b0;
                    state_next = GAME_OVER;
                end else if (shot_by_pc_reg) begin
                    tmo_next   = '0;
                    state_next = P_SELECT;
                end else begin
                    pick_first_next = 1'b1;
                    state_next      = PC_PICK;
                end
            end

            PC_PICK: begin
                // First cycle seeds the probe; then walk forward to a free cell.
                if (pick_first_reg) begin
                    idx_next = lfsr_idx;
                end else if (cell_tried(pick_cell)) begin
                    idx_next = (idx_reg == IDX_W'(CELLS - 1)) ? '0 : idx_reg + IDX_W'(1);
                end else begin
                    state_next = PC_FIRE;
                end
            end

            PC_FIRE: begin
                pl_wr_en        = 1'b1;
                pl_wr_val       = (pick_cell == SHIP) ? HIT : MISS;
                if (pick_cell == SHIP && pl_life_reg != '0) begin
                    pl_life_next = pl_life_reg - L'(1);
                end
                shot_valid_next = 1'b1;
                shot_by_pc_next = 1'b1;
                shot_hit_next   = (pick_cell == SHIP);
                shot_row_next   = pick_row;
                shot_col_next   = pick_col;
                state_next      = RESOLVE;
            end

            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            row_reg        <= '0;
            col_reg        <= '0;
            tmo_reg        <= '0;
            idx_reg        <= '0;
            pick_first_reg <= 1'b0;
            pl_life_reg    <= '0;
            pc_life_reg    <= '0;
            shot_valid_reg <= 1'b0;
            shot_by_pc_reg <= 1'b0;
            shot_hit_reg   <= 1'b0;
            shot_row_reg   <= '0;
            shot_col_reg   <= '0;
            timeout_reg    <= 1'b0;
            repeat_reg     <= 1'b0;
            won_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            row_reg        <= row_next;
            col_reg        <= col_next;
            tmo_reg        <= tmo_next;
            idx_reg        <= idx_next;
            pick_first_reg <= pick_first_next;
            pl_life_reg    <= pl_life_next;
            pc_life_reg    <= pc_life_next;
            shot_valid_reg <= shot_valid_next;
            shot_by_pc_reg <= shot_by_pc_next;
            shot_hit_reg   <= shot_hit_next;
            shot_row_reg   <= shot_row_next;
            shot_col_reg   <= shot_col_next;
            timeout_reg    <= timeout_next;
            repeat_reg     <= repeat_next;
            won_reg        <= won_next;
        end
    end

    // Both boards in one process so every cell has a single driver.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CELLS; i++) begin
                pl_cells_reg[i] <= EMPTY;
                pc_cells_reg[i] <= EMPTY;
            end
        end else begin
            for (int i = 0; i < CELLS; i++) begin
                if (load_boards) begin
                    pl_cells_reg[i] <= player_ships[i] ? SHIP : EMPTY;
                    pc_cells_reg[i] <= pc_ships[i] ? SHIP : EMPTY;
                end else begin
                    if (pl_wr_en && idx_reg == IDX_W'(i)) begin
                        pl_cells_reg[i] <= pl_wr_val;
                    end
                    if (pc_wr_en && cur_idx == IDX_W'(i)) begin
                        pc_cells_reg[i] <= pc_wr_val;
                    end
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CELLS; gi++) begin : g_board_out
            assign player_board[2*gi +: 2] = pl_cells_reg[gi];
            // Fog of war: untouched PC ships look like water.
            assign pc_board[2*gi +: 2]     = (pc_cells_reg[gi] == SHIP) ? EMPTY : pc_cells_reg[gi];
        end
    endgenerate

    assign cursor_row  = row_reg;
    assign cursor_col  = col_reg;
    assign player_turn = (state_reg == P_SELECT);
    assign game_over   = (state_reg == GAME_OVER);
    assign player_won  = won_reg;
    assign shot_valid  = shot_valid_reg;
    assign shot_by_pc  = shot_by_pc_reg;
    assign shot_hit    = shot_hit_reg;
    assign shot_row    = shot_row_reg;
    assign shot_col    = shot_col_reg;
    assign player_life = pl_life_reg;
    assign pc_life     = pc_life_reg;
    assign timeout_evt = timeout_reg;
    assign repeat_err  = repeat_reg;

endmodule
